// File: rtl/wb_uart.sv
// wb_uart: Wishbone pipelined slave UART (8N1) with a TX FIFO and a
// single RX holding register.
//
// Ports:
//   sys_clk_i    clock
//   sys_rst_i    asynchronous active-high reset
//   wbs_adr_i    word address (only [1:0] decoded)
//   wbs_cyc_i    bus cycle
//   wbs_stb_i    strobe (pre-gated by the address decoder)
//   wbs_we_i     write enable
//   wbs_dat_i    write data
//   wbs_dat_o    registered read data
//   wbs_ack_o    registered acknowledge, one cycle after stb
//   wbs_stall_o  tied 0
//   uart_txd_o   serial transmit, idles high
//   uart_rxd_i   serial receive, asynchronous to sys_clk_i
//
// Register map: 0 DATA, 1 STATUS, 2 DIV, 3 reserved (reads 0).
// Reads never have side effects; popping RX is a STATUS write.
module wb_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TX_DEPTH     = 4
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [1:0]  wbs_adr_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [15:0] wbs_dat_i,
    output logic [15:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_stall_o,
    output logic        uart_txd_o,
    input  logic        uart_rxd_i
);

    localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(TX_DEPTH);
    localparam logic [15:0] C_DIV_RST = 16'(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Bus decode
    logic w_xfer;
    logic w_wr_data;
    logic w_wr_stat;
    logic w_wr_div;

    assign w_xfer    = wbs_cyc_i & wbs_stb_i;
    assign w_wr_data = w_xfer & wbs_we_i & (wbs_adr_i == 2'd0);
    assign w_wr_stat = w_xfer & wbs_we_i & (wbs_adr_i == 2'd1);
    assign w_wr_div  = w_xfer & wbs_we_i & (wbs_adr_i == 2'd2);

    assign wbs_stall_o = 1'b0;

    // Register state
    logic [15:0] r_div;
    logic        r_tx_ovf;
    logic        r_rx_ovf;
    logic        r_frm_err;
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;

    // TX FIFO
    logic [7:0]  r_fifo [TX_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0] r_count;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_push;
    logic        w_pop;

    // TX FSM
    state_t      r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [15:0] r_tx_div;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_sh;
    logic        r_txd;
    logic        w_tx_busy;

    // RX path
    logic        r_rx_s1;
    logic        r_rx_s2;
    state_t      r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [15:0] r_rx_div;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sh;
    logic        w_rx_done;
    logic        w_rx_good;
    logic        w_rx_pop;

    // Full uses the registered count, so a push while full is dropped
    // even when the shifter pops in the same cycle.
    assign w_tx_full  = (r_count == C_DEPTH);
    assign w_tx_empty = (r_count == '0);
    assign w_push     = w_wr_data & ~w_tx_full;
    assign w_pop      = ~w_tx_empty &
                        ((r_tx_state == S_IDLE) |
                         ((r_tx_state == S_STOP) && (r_tx_cnt == 16'd0)));
    assign w_tx_busy  = (r_tx_state != S_IDLE);

    assign w_rx_done = (r_rx_state == S_STOP) && (r_rx_cnt == 16'd0);
    assign w_rx_good = w_rx_done & r_rx_s2;
    assign w_rx_pop  = w_wr_stat & wbs_dat_i[0];

    assign uart_txd_o = r_txd;

    // Read mux
    logic [15:0] w_rd_data;

    always_comb begin
        w_rd_data = 16'h0;
        unique case (wbs_adr_i)
            2'd0: w_rd_data = {8'h0, r_rx_data};
            2'd1: w_rd_data = {9'h0, r_frm_err, r_rx_ovf, r_tx_ovf,
                               r_rx_valid, w_tx_full, w_tx_empty,
                               w_tx_busy};
            2'd2: w_rd_data = r_div;
            2'd3: w_rd_data = 16'h0;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 16'h0;
        end else begin
            wbs_ack_o <= w_xfer;
            if (w_xfer)
                wbs_dat_o <= w_rd_data;
        end
    end

    // Divisor and TX overflow flag
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_div    <= C_DIV_RST;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_wr_div)
                r_div <= (wbs_dat_i < 16'd4) ? 16'd4 : wbs_dat_i;
            if (w_wr_data & w_tx_full)
                r_tx_ovf <= 1'b1;
            else if (w_wr_stat & wbs_dat_i[2])
                r_tx_ovf <= 1'b0;
        end
    end

    // FIFO storage needs no reset; pointers and count define contents.
    always_ff @(posedge sys_clk_i) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= wbs_dat_i[7:0];
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // TX FSM; the divisor is latched per frame.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_div   <= C_DIV_RST;
            r_tx_bit   <= 3'd0;
            r_tx_sh    <= 8'h0;
            r_txd      <= 1'b1;
        end else begin
            unique case (r_tx_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_sh    <= r_fifo[r_rd_ptr];
                        r_tx_div   <= r_div;
                        r_tx_cnt   <= r_div - 16'd1;
                        r_txd      <= 1'b0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_cnt   <= r_tx_div - 16'd1;
                        r_txd      <= r_tx_sh[0];
                        r_tx_sh    <= r_tx_sh >> 1;
                        r_tx_bit   <= 3'd0;
                        r_tx_state <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_cnt <= r_tx_div - 16'd1;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_txd    <= r_tx_sh[0];
                            r_tx_sh  <= r_tx_sh >> 1;
                            r_tx_bit <= r_tx_bit + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_tx_cnt == 16'd0) begin
                        // Chain straight into the next start bit.
                        if (w_pop) begin
                            r_tx_sh    <= r_fifo[r_rd_ptr];
                            r_tx_div   <= r_div;
                            r_tx_cnt   <= r_div - 16'd1;
                            r_txd      <= 1'b0;
                            r_tx_state <= S_START;
                        end else begin
                            r_tx_state <= S_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // RX synchronizer, idles high
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rxd_i;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // RX FSM; START waits half a bit so later samples land mid-bit.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_div   <= C_DIV_RST;
            r_rx_bit   <= 3'd0;
            r_rx_sh    <= 8'h0;
        end else begin
            unique case (r_rx_state)
                S_IDLE: begin
                    if (!r_rx_s2) begin
                        r_rx_div   <= r_div;
                        r_rx_cnt   <= (r_div >> 1) - 16'd1;
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == 16'd0) begin
                        if (!r_rx_s2) begin
                            r_rx_cnt   <= r_rx_div - 16'd1;
                            r_rx_bit   <= 3'd0;
                            r_rx_state <= S_DATA;
                        end else begin
                            r_rx_state <= S_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_rx_cnt == 16'd0) begin
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        r_rx_cnt <= r_rx_div - 16'd1;
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= S_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_rx_cnt == 16'd0)
                        r_rx_state <= S_IDLE;
                    else
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                end
            endcase
        end
    end

    // RX holding register and flags. A pop in the completion cycle
    // frees the slot, so the new byte loads without an overflow.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h0;
            r_rx_ovf   <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            if (w_rx_good & (~r_rx_valid | w_rx_pop)) begin
                r_rx_data  <= r_rx_sh;
                r_rx_valid <= 1'b1;
            end else if (w_rx_pop) begin
                r_rx_valid <= 1'b0;
            end

            if (w_rx_good & r_rx_valid & ~w_rx_pop)
                r_rx_ovf <= 1'b1;
            else if (w_wr_stat & wbs_dat_i[1])
                r_rx_ovf <= 1'b0;

            if (w_rx_done & ~r_rx_s2)
                r_frm_err <= 1'b1;
            else if (w_wr_stat & wbs_dat_i[3])
                r_frm_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// tb_wb_uart: self-checking bench for wb_uart.
// Random bytes against a frame-level model of the serial line and flags.
module tb_wb_uart;

    localparam int DIV_RST = 434;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        ack;
    logic        stall;
    logic        txd;
    logic        rxd;

    int passed = 0;
    int total  = 0;

    // Model state
    logic       m_rx_valid;
    logic       m_rx_ovf;
    logic       m_frm;
    logic       m_tx_ovf;
    logic [7:0] m_rx_data;

    wb_uart #(.CLKS_PER_BIT(DIV_RST), .TX_DEPTH(DEPTH)) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .wbs_adr_i   (adr),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_dat_i   (dat_i),
        .wbs_dat_o   (dat_o),
        .wbs_ack_o   (ack),
        .wbs_stall_o (stall),
        .uart_txd_o  (txd),
        .uart_rxd_i  (rxd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_status();
        return {9'h0, m_frm, m_rx_ovf, m_tx_ovf, m_rx_valid,
                1'b0, 1'b1, 1'b0};
    endfunction

    task automatic model_reset();
        m_rx_valid = 1'b0;
        m_rx_ovf   = 1'b0;
        m_frm      = 1'b0;
        m_tx_ovf   = 1'b0;
        m_rx_data  = 8'h0;
    endtask

    task automatic model_rx(input logic [7:0] b, input logic stop);
        if (!stop)
            m_frm = 1'b1;
        else if (!m_rx_valid) begin
            m_rx_data  = b;
            m_rx_valid = 1'b1;
        end else
            m_rx_ovf = 1'b1;
    endtask

    task automatic bus_idle();
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = 2'd0;
        dat_i = 16'h0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        adr   = a;
        dat_i = d;
        we    = 1'b1;
        cyc   = 1'b1;
        stb   = 1'b1;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a,
                            output logic [15:0] d, output logic k);
        adr = a;
        we  = 1'b0;
        cyc = 1'b1;
        stb = 1'b1;
        @(posedge clk);
        #1;
        d = dat_o;
        k = ack;
        bus_idle();
    endtask

    // Expected line level k cycles after the first start bit edge.
    function automatic logic exp_txd(input logic [7:0] b[6], input int nf,
                                     input int div, input int k);
        int fl;
        int bi;
        fl = 10 * div;
        if (k >= nf * fl)
            return 1'b1;
        bi = (k % fl) / div;
        if (bi == 0)
            return 1'b0;
        if (bi == 9)
            return 1'b1;
        return b[k / fl][bi - 1];
    endfunction

    // Cycle c drives a DATA write (c < nw) or a STATUS read, then samples.
    task automatic run_tx(input logic [7:0] b[6], input int nw,
                          input int nf, input int div,
                          output int wave_err, output int busy_err);
        int   last;
        int   j;
        logic eb;
        wave_err = 0;
        busy_err = 0;
        last = nf * 10 * div + 2 * div;
        for (int c = 0; c <= last; c++) begin
            if (c < nw) begin
                adr   = 2'd0;
                we    = 1'b1;
                dat_i = {8'h0, b[c]};
            end else begin
                adr   = 2'd1;
                we    = 1'b0;
                dat_i = 16'h0;
            end
            cyc = 1'b1;
            stb = 1'b1;
            @(posedge clk);
            #1;
            if (c >= 1 && txd !== exp_txd(b, nf, div, c - 1))
                wave_err++;
            if (c >= nw) begin
                j  = c - 1;
                eb = (j >= 1) && (j <= nf * 10 * div);
                if (dat_o[0] !== eb || ack !== 1'b1)
                    busy_err++;
            end
        end
        bus_idle();
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop,
                            input int div);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (div) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        repeat (div + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        k;
        bus_idle();
        rxd = 1'b1;
        model_reset();
        #12;
        total++;
        if (ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", ack);
        else passed++;
        total++;
        if (dat_o !== 16'h0) $display("FAIL rst_dat: got %h want 0000", dat_o);
        else passed++;
        total++;
        if (txd !== 1'b1) $display("FAIL rst_txd: got %b want 1", txd);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_write(2'd0, 16'($urandom_range(0, 255)));
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (txd !== 1'b0) $display("FAIL tx_start_low: got %b want 0", txd);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (txd !== 1'b1) $display("FAIL async_rst_txd: got %b want 1", txd);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        bus_read(2'd1, d, k);
        total++;
        if (d !== 16'h0002 || k !== 1'b1)
            $display("FAIL post_rst_status: got %h ack %b want 0002 ack 1", d, k);
        else passed++;
        bus_read(2'd2, d, k);
        total++;
        if (d !== 16'(DIV_RST) || k !== 1'b1)
            $display("FAIL post_rst_div: got %0d ack %b want %0d ack 1", d, k, DIV_RST);
        else passed++;
    endtask

    task automatic test_bus_read();
        int good;
        good = 0;
        adr = 2'd2;
        we  = 1'b0;
        cyc = 1'b1;
        stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1 && dat_o === 16'(DIV_RST))
                good++;
        end
        bus_idle();
        total++;
        if (good != 10) $display("FAIL burst_read: got %0d good acks want 10", good);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (ack !== 1'b0) $display("FAIL ack_drop: got %b want 0", ack);
        else passed++;
    endtask

    task automatic test_div();
        logic [15:0] d;
        logic [15:0] v;
        logic        k;
        v = 16'($urandom_range(0, 3));
        bus_write(2'd2, v);
        bus_read(2'd2, d, k);
        total++;
        if (d !== 16'd4) $display("FAIL div_clamp: wrote %0d got %0d want 4", v, d);
        else passed++;
        v = 16'($urandom_range(4, 65535));
        bus_write(2'd2, v);
        bus_read(2'd2, d, k);
        total++;
        if (d !== v) $display("FAIL div_rw: got %0d want %0d", d, v);
        else passed++;
        bus_write(2'd3, 16'hffff);
        bus_read(2'd3, d, k);
        total++;
        if (d !== 16'h0) $display("FAIL reg3: got %h want 0000", d);
        else passed++;
        bus_write(2'd2, 16'd16);
    endtask

    task automatic test_tx_frame();
        logic [7:0]  b[6];
        logic [15:0] d;
        logic        k;
        int          we_n;
        int          be_n;
        foreach (b[i]) b[i] = 8'h0;
        b[0] = 8'h55;
        run_tx(b, 1, 1, 16, we_n, be_n);
        total++;
        if (we_n != 0) $display("FAIL tx_55_wave: got %0d bad cycles want 0", we_n);
        else passed++;
        total++;
        if (be_n != 0) $display("FAIL tx_55_busy: got %0d bad cycles want 0", be_n);
        else passed++;
        b[0] = 8'($urandom_range(0, 255));
        run_tx(b, 1, 1, 16, we_n, be_n);
        total++;
        if (we_n != 0 || be_n != 0)
            $display("FAIL tx_rand: byte %h wave %0d busy %0d want 0 0", b[0], we_n, be_n);
        else passed++;
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL tx_idle_status: got %h want %h", d, exp_status());
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b[6];
        logic [15:0] d;
        logic        k;
        int          we_n;
        int          be_n;
        int          nf;
        foreach (b[i]) b[i] = 8'($urandom_range(0, 255));
        // FIFO plus the shifter hold DEPTH+1 bytes; the rest are dropped.
        nf = (6 < DEPTH + 1) ? 6 : DEPTH + 1;
        m_tx_ovf = (6 > DEPTH + 1);
        run_tx(b, 6, nf, 16, we_n, be_n);
        total++;
        if (we_n != 0) $display("FAIL b2b_wave: got %0d bad cycles want 0", we_n);
        else passed++;
        total++;
        if (be_n != 0) $display("FAIL b2b_busy: got %0d bad cycles want 0", be_n);
        else passed++;
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL b2b_ovf: got %h want %h", d, exp_status());
        else passed++;
        bus_write(2'd1, 16'h0004);
        m_tx_ovf = 1'b0;
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL b2b_ovf_clr: got %h want %h", d, exp_status());
        else passed++;
    endtask

    task automatic rx_pair(input logic [7:0] b1, input logic [7:0] b2);
        logic [15:0] d;
        logic        k;
        int          good;
        rx_frame(b1, 1'b1, 16);
        model_rx(b1, 1'b1);
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL rx1_status: got %h want %h", d, exp_status());
        else passed++;
        good = 0;
        adr = 2'd0;
        we  = 1'b0;
        cyc = 1'b1;
        stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1 && dat_o === {8'h0, m_rx_data})
                good++;
        end
        bus_idle();
        total++;
        if (good != 10) $display("FAIL rx_data_reads: got %0d good want 10 (data %h)", good, m_rx_data);
        else passed++;
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL rx_reads_no_pop: got %h want %h", d, exp_status());
        else passed++;
        rx_frame(b2, 1'b1, 16);
        model_rx(b2, 1'b1);
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL rx_ovf_status: got %h want %h", d, exp_status());
        else passed++;
        bus_read(2'd0, d, k);
        total++;
        if (d !== {8'h0, m_rx_data}) $display("FAIL rx_ovf_data: got %h want %h", d, m_rx_data);
        else passed++;
        bus_write(2'd1, 16'h0003);
        m_rx_valid = 1'b0;
        m_rx_ovf   = 1'b0;
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL rx_pop_clr: got %h want %h", d, exp_status());
        else passed++;
    endtask

    task automatic test_rx();
        rx_pair(8'hA3, 8'h11);
        rx_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_rx_errors();
        logic [15:0] d;
        logic        k;
        logic [7:0]  b;
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL glitch: got %h want %h", d, exp_status());
        else passed++;
        b = 8'($urandom_range(0, 255));
        rx_frame(b, 1'b1, 16);
        model_rx(b, 1'b1);
        rx_frame(8'($urandom_range(0, 255)), 1'b0, 16);
        model_rx(8'h0, 1'b0);
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL frm_err_status: got %h want %h", d, exp_status());
        else passed++;
        bus_read(2'd0, d, k);
        total++;
        if (d !== {8'h0, m_rx_data}) $display("FAIL frm_err_data: got %h want %h", d, m_rx_data);
        else passed++;
        bus_write(2'd1, 16'h0009);
        m_rx_valid = 1'b0;
        m_frm      = 1'b0;
        bus_read(2'd1, d, k);
        total++;
        if (d !== exp_status()) $display("FAIL frm_err_clr: got %h want %h", d, exp_status());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_bus_read();
        test_div();
        test_tx_frame();
        test_back_to_back();
        test_rx();
        test_rx_errors();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_uart.md
Name: wb_uart

Overview:
Wishbone pipelined slave UART, the responder on the J1 data bus (wbd), mapped by an external address decoder that gates stb.
Transmits and receives 8N1 serial frames. TX has a 4-deep FIFO; RX has a single holding register.
The J1 master issues a read every cycle with stb asserted, so reads never have side effects. An RX pop is a register write.

Parameters:
CLKS_PER_BIT, 434, reset value of the baud divisor (clocks per bit).
TX_DEPTH, 4, TX FIFO depth in entries; must be a power of 2.

Ports:
sys_clk_i  input  1  clock
sys_rst_i  input  1  reset, asynchronous, active-high
wbs  if_wb.slave  -  Wishbone slave. Signals used: adr (word address; only adr[1:0] decoded), cyc, stb, we, dat_i[15:0], dat_o[15:0], ack, stall.
uart_txd_o  output  1  serial transmit; idles high
uart_rxd_i  input  1  serial receive; asynchronous to sys_clk_i

Behaviour:
- Reset values:
  - Outputs: ack=0, dat_o=0, uart_txd_o=1.
  - FIFO empty; both FSMs IDLE.
  - div=CLKS_PER_BIT; all status flags 0.
- Bus timing:
  - stall tied 0.
  - A transfer occurs in any cycle with cyc&stb.
  - ack is registered and asserts exactly one cycle later.
  - dat_o is registered; it holds the register addressed in the stb cycle.
  - Back-to-back transfers are accepted every cycle.
  - Write effects become visible in the cycle after the stb cycle.
- Register map (adr[1:0]):
  - 0 DATA
    - Read: {8'h0, rx_data}.
    - Write: push dat_i[7:0] into the TX FIFO. If the FIFO is full, the data is dropped and tx_ovf is set (sticky).
  - 1 STATUS
    - Read: {9'h0, frm_err, rx_ovf, tx_ovf, rx_valid, tx_full, tx_empty, tx_busy}.
    - Write-1 actions: bit0 pops RX (rx_valid<=0); bit1 clears rx_ovf; bit2 clears tx_ovf; bit3 clears frm_err.
  - 2 DIV
    - Read/write of the 16-bit divisor.
    - Written values below 4 load 4.
  - 3 reads 0; writes ignored.
- TX FIFO:
  - Circular buffer with count.
  - Full is evaluated on the registered count before a same-cycle pop. A push while full is dropped even if the shifter pops in the same cycle.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - In IDLE, when the FIFO is non-empty, pop the head into the shifter, latch div, and go to START. txd goes low at the next edge.
  - START is 0 for div clocks.
  - DATA sends 8 bits LSB first, div clocks each.
  - STOP is 1 for div clocks.
  - On STOP end, if the FIFO is non-empty, go straight to START (no idle bit). Otherwise go to IDLE.
  - tx_busy=1 whenever the FSM is not IDLE.
  - A DIV write mid-frame takes effect at the next frame.
- RX path:
  - uart_rxd_i passes through a 2-FF synchronizer (reset to 1).
  - IDLE: on synchronized 0, go to START and latch div.
  - START: wait div/2 (integer shift). If the line is still 0, go to DATA. Otherwise it is a false start: go to IDLE.
  - DATA: sample every div clocks, 8 bits, LSB first.
  - STOP: sample after div clocks.
    - Stop bit 0: discard the byte, set frm_err, go to IDLE.
    - Stop bit 1 with rx_valid=0: load rx_data, set rx_valid=1.
    - Stop bit 1 with rx_valid=1: set rx_ovf; keep the old rx_data.
  - If a pop write and a byte completion fall in the same cycle, the new byte is loaded, rx_valid stays 1, and no overflow is flagged.
  - After STOP, return to IDLE; the next falling edge is detected immediately.
- Arithmetic:
  - Bit counters are 3 bits.
  - Baud counter is 16 bits, counting down from latched div-1 to 0.
- Reset asserted mid-frame:
  - txd goes to 1 immediately (asynchronously).
  - Any partial RX byte is discarded.
  - The FIFO is cleared.

Test Plan:
- Reset mid-frame -> txd=1 asynchronously; after release STATUS reads 16'h0002 and DIV reads 434.
- Bus read of DIV (stb, we=0, adr=2) -> ack one cycle later with dat_o=434. Reads every cycle for 10 cycles -> 10 acks and no change to rx_valid.
- DIV=16, write DATA=0x55 -> txd low for 16 clocks, then bits 1,0,1,0,1,0,1,0 at 16 clocks each, then high 16 clocks. Total frame 160 clocks; tx_busy=1 throughout.
- TX idle, DIV=16, 6 DATA writes in consecutive cycles (A..F) -> 5 frames A..E back-to-back with no gap between frames; F dropped; tx_ovf=1 until cleared by STATUS write 0x4.
- DIV=16, drive 0xA3 at 16 clocks/bit -> rx_valid=1, DATA reads 0x00A3. A second byte 0x11 before pop -> rx_ovf=1, DATA still 0x00A3. STATUS write 0x3 -> rx_valid=0, rx_ovf=0.
- Glitch low for 4 clocks at DIV=16 -> no byte and no frm_err. Frame with stop bit 0 -> frm_err=1, rx_valid unchanged.
